fsub_pipe: RTL and testbench

//  Pipelined IEEE-754 binary32 subtractor, d = s - t, for the FPU issue path.

---
 rtl/fsub_pipe.sv | 192 +++++++++++++++++++
 tb/tb_fsub_pipe.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fsub_pipe.sv
// Three-stage pipelined binary32 subtractor (d = s - t) with valid/ready on both
// sides, a tag carried per operation, round-to-nearest-even and subnormal flush.
module fsub_pipe #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      s,
  input  logic [31:0]      t,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      d,
  output logic             overflow,
  output logic [TAG_W-1:0] out_tag
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------- S1: align ----------------
  logic        s_sign, t_sign, s_zero, t_zero, s_nan, t_nan, s_inf, t_inf, swap;
  logic [7:0]  s_exp, t_exp, g_exp, l_exp, shamt;
  logic [22:0] s_man, t_man, g_man, l_man;
  logic        g_sign, l_sign;
  logic [26:0] sig_g, sig_l, l_aligned;
  logic [53:0] l_shifted;
  logic        spec_d, neg_zero_d;
  logic [31:0] spec_val_d;

  assign s_sign = s[31];
  assign t_sign = ~t[31];
  assign s_exp  = s[30:23];
  assign t_exp  = t[30:23];
  assign s_zero = (s_exp == 8'd0);
  assign t_zero = (t_exp == 8'd0);
  assign s_man  = s_zero ? 23'd0 : s[22:0];
  assign t_man  = t_zero ? 23'd0 : t[22:0];
  assign s_nan  = (s_exp == 8'hFF) && (s[22:0] != 23'd0);
  assign t_nan  = (t_exp == 8'hFF) && (t[22:0] != 23'd0);
  assign s_inf  = (s_exp == 8'hFF) && (s[22:0] == 23'd0);
  assign t_inf  = (t_exp == 8'hFF) && (t[22:0] == 23'd0);

  assign swap   = {t_exp, t_man} > {s_exp, s_man};
  assign g_sign = swap ? t_sign : s_sign;
  assign l_sign = swap ? s_sign : t_sign;
  assign g_exp  = swap ? t_exp  : s_exp;
  assign l_exp  = swap ? s_exp  : t_exp;
  assign g_man  = swap ? t_man  : s_man;
  assign l_man  = swap ? s_man  : t_man;

  assign sig_g     = {g_exp != 8'd0, g_man, 3'b000};
  assign sig_l     = {l_exp != 8'd0, l_man, 3'b000};
  assign shamt     = g_exp - l_exp;
  assign l_shifted = {sig_l, 27'd0} >> shamt;
  // Bits shifted past the round position are ORed into the sticky bit.
  assign l_aligned = (shamt > 8'd25) ? {26'd0, |sig_l}
                   : {l_shifted[53:28], l_shifted[27] | (|l_shifted[26:0])};

  assign neg_zero_d = s_zero && t_zero && s_sign && t_sign;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    spec_d     = 1'b0;
    spec_val_d = 32'd0;
    if (s_nan || t_nan) begin
      spec_d     = 1'b1;
      spec_val_d = QNAN;
    end else if (s_inf && t_inf) begin
      spec_d     = 1'b1;
      spec_val_d = (s_sign != t_sign) ? QNAN : {s_sign, 8'hFF, 23'd0};
    end else if (s_inf) begin
      spec_d     = 1'b1;
      spec_val_d = {s_sign, 8'hFF, 23'd0};
    end else if (t_inf) begin
      spec_d     = 1'b1;
      spec_val_d = {t_sign, 8'hFF, 23'd0};
    end
  end

  logic             s1_valid, s1_spec, s1_neg_zero, s1_sign, s1_sub;
  logic [31:0]      s1_spec_val;
  logic [TAG_W-1:0] s1_tag;
  logic [7:0]       s1_exp;
  logic [26:0]      s1_sig_g, s1_sig_l;

  // ---------------- S2: add/sub + leading-zero count ----------------
  logic [27:0] sum_d;
  assign sum_d = s1_sub ? ({1'b0, s1_sig_g} - {1'b0, s1_sig_l})
                        : ({1'b0, s1_sig_g} + {1'b0, s1_sig_l});

  logic             s2_valid, s2_spec, s2_neg_zero, s2_sign;
  logic [31:0]      s2_spec_val;
  logic [TAG_W-1:0] s2_tag;
  logic [7:0]       s2_exp;
  logic [27:0]      s2_sum;
  logic [4:0]       s2_lzc;

  // ---------------- S3: normalize, round, range ----------------
  logic [26:0] norm;
  logic [9:0]  exp_n, exp_f;
  logic        inc, ovf_next;
  logic [24:0] rounded;
  logic [22:0] man;
  logic [31:0] d_next;

  always_comb begin
    norm     = 27'd0;
    exp_n    = 10'd0;
    d_next   = 32'd0;
    ovf_next = 1'b0;
    if (s2_sum[27]) begin
      norm  = {s2_sum[27:2], s2_sum[1] | s2_sum[0]};
      exp_n = {2'b00, s2_exp} + 10'd1;
    end else begin
      norm  = s2_sum[26:0] << s2_lzc;
      exp_n = {2'b00, s2_exp} - {5'd0, s2_lzc};
    end
    inc     = norm[2] & (norm[3] | norm[1] | norm[0]);
    rounded = {1'b0, norm[26:3]} + {24'd0, inc};
    exp_f   = exp_n + {9'd0, rounded[24]};
    man     = rounded[24] ? rounded[23:1] : rounded[22:0];
    // exp_f[9] set means the exponent went negative.
    if (s2_spec)
      d_next = s2_spec_val;
    else if (s2_sum == 28'd0)
      d_next = {s2_neg_zero, 31'd0};
    else if (exp_f[9] || exp_f == 10'd0)
      d_next = {s2_sign, 31'd0};
    else if (exp_f >= 10'd255) begin
      d_next   = {s2_sign, 8'hFF, 23'd0};
      ovf_next = 1'b1;
    end else
      d_next = {s2_sign, exp_f[7:0], man};
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      d         <= 32'd0;
      overflow  <= 1'b0;
      out_tag   <= '0;
    end else if (adv) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      d         <= d_next;
      overflow  <= ovf_next;
      out_tag   <= s2_tag;
    end
  end

  // NOTE: datapath registers carry no reset; their contents only matter when the
  // matching valid bit is set, and the valid bits are reset above.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_tag      <= in_tag;
      s1_spec     <= spec_d;
      s1_spec_val <= spec_val_d;
      s1_neg_zero <= neg_zero_d;
      s1_sign     <= g_sign;
      s1_sub      <= g_sign ^ l_sign;
      s1_exp      <= g_exp;
      s1_sig_g    <= sig_g;
      s1_sig_l    <= l_aligned;
      s2_tag      <= s1_tag;
      s2_spec     <= s1_spec;
      s2_spec_val <= s1_spec_val;
      s2_neg_zero <= s1_neg_zero;
      s2_sign     <= s1_sign;
      s2_exp      <= s1_exp;
      s2_sum      <= sum_d;
      s2_lzc      <= lzc27(sum_d[26:0]);
    end
  end

endmodule

// File: tb/tb_fsub_pipe.sv
// Directed bench for fsub_pipe: expected results queued at acceptance and
// compared by a monitor when the result handshake completes.
module tb_fsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, overflow;
  logic [31:0] s, t, d;
  logic [4:0]  in_tag, out_tag;

  typedef struct packed {
    logic [4:0]  tag;
    logic [31:0] d;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  fsub_pipe #(.TAG_W(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .t(t), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .d(d), .overflow(overflow),
    .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  // Scoreboard monitor: inputs change only 1 time unit after posedge, so the
  // negedge sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL spurious_result: observed tag %0d d %h, expected no result", out_tag, d);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("result_tag", {27'd0, out_tag}, {27'd0, e.tag});
        check("result_d", d, e.d);
        check("result_ovf", {31'd0, overflow}, {31'd0, e.ovf});
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one operation, wait (bounded) for acceptance, queue its expected result.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] tg,
                      input logic [31:0] ed, input logic eo);
    int n;
    in_valid = 1'b1;
    s = a;
    t = b;
    in_tag = tg;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) sb.push_back('{tag: tg, d: ed, ovf: eo});
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    check("drain_outstanding", sb.size(), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    s = 32'd0;
    t = 32'd0;
    in_tag = 5'd0;
    out_ready = 1'b1;
    repeat (2) cycle();
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_d", d, 32'd0);
    check("reset_ovf", {31'd0, overflow}, 32'd0);
    check("reset_out_tag", {27'd0, out_tag}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    cycle();

    // 3 - 1 = 2, with latency observed on an empty pipe
    send(32'h4040_0000, 32'h3F80_0000, 5'd3, 32'h4000_0000, 1'b0);
    check("lat_edge0", {31'd0, out_valid}, 32'd0);
    cycle();
    check("lat_edge1", {31'd0, out_valid}, 32'd0);
    cycle();
    check("lat_edge2", {31'd0, out_valid}, 32'd1);
    drain();

    // Back-to-back directed operations
    send(32'h3F80_0000, 32'h3F80_0000, 5'd1,  32'h0000_0000, 1'b0); // x - x
    send(32'h8000_0000, 32'h0000_0000, 5'd2,  32'h8000_0000, 1'b0); // -0 - +0
    send(32'hBF80_0000, 32'hBF80_0000, 5'd4,  32'h0000_0000, 1'b0); // neg x - x
    send(32'h3F80_0000, 32'h3300_0000, 5'd5,  32'h3F80_0000, 1'b0); // tie, even down
    send(32'h3F80_0001, 32'hB380_0000, 5'd6,  32'h3F80_0002, 1'b0); // tie, odd up
    send(32'h3F80_0000, 32'hB380_0000, 5'd7,  32'h3F80_0000, 1'b0); // tie on add
    send(32'h3F80_0000, 32'h0080_0000, 5'd8,  32'h3F80_0000, 1'b0); // sticky collapse
    send(32'h7F7F_FFFF, 32'hFF7F_FFFF, 5'd9,  32'h7F80_0000, 1'b1); // overflow
    send(32'h7F80_0000, 32'h7F80_0000, 5'd10, 32'h7FC0_0000, 1'b0); // inf - inf
    send(32'h7F80_0000, 32'hFF80_0000, 5'd11, 32'h7F80_0000, 1'b0); // inf - -inf
    send(32'h3F80_0000, 32'h7F80_0000, 5'd12, 32'hFF80_0000, 1'b0); // 1 - inf
    send(32'h7FC0_0000, 32'h3F80_0000, 5'd13, 32'h7FC0_0000, 1'b0); // NaN
    send(32'h3F80_0000, 32'hFFC1_2345, 5'd14, 32'h7FC0_0000, 1'b0); // NaN in t
    send(32'h0040_0000, 32'h0000_0000, 5'd15, 32'h0000_0000, 1'b0); // subnormal flush
    send(32'h8040_0000, 32'h0000_0000, 5'd16, 32'h8000_0000, 1'b0); // -subnormal flush
    send(32'h0080_0000, 32'h00C0_0000, 5'd17, 32'h8000_0000, 1'b0); // underflow
    send(32'h3F80_0000, 32'h3E80_0000, 5'd18, 32'h3F40_0000, 1'b0); // 1 - 0.25
    send(32'h3F80_0000, 32'h4000_0000, 5'd19, 32'hBF80_0000, 1'b0); // 1 - 2
    send(32'h3F80_0000, 32'hBF80_0000, 5'd20, 32'h4000_0000, 1'b0); // 1 - -1
    drain();

    // Output stall: 2 cycles of out_ready=0 once the first of 4 results is valid
    send(32'h3F80_0000, 32'h3E80_0000, 5'd21, 32'h3F40_0000, 1'b0);
    send(32'h3F80_0000, 32'h4000_0000, 5'd22, 32'hBF80_0000, 1'b0);
    send(32'h3F80_0000, 32'hBF80_0000, 5'd23, 32'h4000_0000, 1'b0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    s = 32'h3F80_0001;
    t = 32'hB380_0000;
    in_tag = 5'd24;
    repeat (2) begin
      @(negedge clk);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_d", d, 32'h3F40_0000);
      check("stall_out_tag", {27'd0, out_tag}, 32'd21);
      check("stall_ovf", {31'd0, overflow}, 32'd0);
      cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", {31'd0, in_ready}, 32'd1);
    if (in_ready) sb.push_back('{tag: 5'd24, d: 32'h3F80_0002, ovf: 1'b0});
    cycle();
    in_valid = 1'b0;
    drain();

    // Reset with two operations in flight
    send(32'h4040_0000, 32'h3F80_0000, 5'd25, 32'h4000_0000, 1'b0);
    send(32'h3F80_0000, 32'h4000_0000, 5'd26, 32'hBF80_0000, 1'b0);
    rst = 1'b1;
    sb.delete();
    cycle();
    rst = 1'b0;
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    check("flush_d", d, 32'd0);
    check("flush_out_tag", {27'd0, out_tag}, 32'd0);
    cycle();
    check("flush_out_valid_next", {31'd0, out_valid}, 32'd0);
    send(32'h3F80_0000, 32'h3E80_0000, 5'd27, 32'h3F40_0000, 1'b0);
    check("post_rst_lat0", {31'd0, out_valid}, 32'd0);
    cycle();
    check("post_rst_lat1", {31'd0, out_valid}, 32'd0);
    cycle();
    check("post_rst_lat2", {31'd0, out_valid}, 32'd1);
    check("post_rst_tag", {27'd0, out_tag}, 32'd27);
    drain();
    repeat (8) cycle();
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
